cmd_tx_scheduler: RTL and testbench
===================================

CMD_TX_SCHEDULER -- requirements
Module: cmd_tx_scheduler

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, echo FIFO depth in bytes (power of two, 2..16).
REQ-002 SHALL have port Clock  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port Reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port RxData  input  8  received UART byte.
REQ-005 SHALL have port RxValid  input  1  one-cycle strobe, RxData valid.
REQ-006 SHALL have port DataByte  input  8  stream byte from acquisition datapath.
REQ-007 SHALL have port DataValid  input  1  DataByte available; held until DataAck.
REQ-008 SHALL have port DataAck  output  1  one-cycle pulse, DataByte consumed.
REQ-009 SHALL have port TxData  output  8  byte offered to UART transmitter.
REQ-010 SHALL have port TxValid  output  1  TxData valid; transfer when TxValid and TxReady both high.
REQ-011 SHALL have port TxReady  input  1  transmitter can accept a byte.
REQ-012 SHALL have ports EchoEnabled, StreamEnabled, Overflow  output  1 each  mode flags, sticky echo-FIFO overflow.

Function
REQ-013 Mode decode SHALL act on each RxValid byte: 101 'e' clears EchoEnabled, 69 'E' sets it, 115 's' sets StreamEnabled, 83 'S' clears it; other bytes leave modes unchanged; change visible the cycle after RxValid.
REQ-014 A received byte SHALL be pushed into the echo FIFO iff EchoEnabled was high in the RxValid cycle (pre-update value): 'e' is echoed, 'E' received while off is not.
REQ-015 Push into a full FIFO SHALL drop the byte and set Overflow, even if a pop occurs the same cycle.
REQ-016 Scheduler FSM states: IDLE, SEND_ECHO, SEND_DATA; encoding is an implementation choice.
REQ-017 IDLE: echo pending = FIFO non-empty; data pending = DataValid and StreamEnabled; only echo pending -> SEND_ECHO; only data pending -> SEND_DATA; both -> state not granted last (round-robin, initial last-grant = data, so echo first).
REQ-018 SEND_ECHO: TxValid=1, TxData = FIFO head; on TxReady pop FIFO, record last-grant = echo, go to IDLE.
REQ-019 SEND_DATA: TxValid=1, TxData = DataByte; on TxReady pulse DataAck one cycle, record last-grant = data, go to IDLE.
REQ-020 Once TxValid is high, TxValid and TxData SHALL stay stable until transfer; clearing StreamEnabled or EchoEnabled never withdraws an offered byte.
REQ-021 TxValid SHALL be low in IDLE; minimum spacing between transfers is two cycles (one IDLE cycle).
REQ-022 Latency: RxValid at cycle N with echo on, FIFO empty, scheduler idle -> TxValid high at N+2.
REQ-023 FIFO push and pop in the same cycle (not full) SHALL both occur, count unchanged.
REQ-024 FIFO pointers SHALL wrap modulo FIFO_DEPTH; order strictly first-in first-out.

Reset
REQ-025 On Reset: state IDLE, FIFO empty, last-grant = data, EchoEnabled=1, StreamEnabled=0, Overflow=0, TxValid=0, DataAck=0, TxData=0.
REQ-026 Reset mid-transfer SHALL drop the offered byte with TxValid low the following cycle; Reset overrides RxValid the same cycle.

Configuration
REQ-027 With CMD_SCHED_STATUS_EN defined, byte 63 '?' SHALL additionally push status byte 0x30 | {Overflow, StreamEnabled, EchoEnabled} (bits 2:0) into the FIFO after its echo (if echoed), and clear Overflow; if FIFO lacks room for either byte, apply REQ-015 per byte.
REQ-028 Without CMD_SCHED_STATUS_EN, '?' SHALL be an ordinary byte; no status logic present.

Verification
REQ-029 Reset, RxValid 'A' (65), TxReady=1 -> TxValid at +2 cycles, TxData=65, one transfer.
REQ-030 Send 'e' then 'B' -> only 101 transmitted, EchoEnabled=0; then 'E' -> not echoed, EchoEnabled=1.
REQ-031 TxReady=0, 6 bytes with FIFO_DEPTH=4 -> 4 bytes held, Overflow=1; release TxReady -> first four bytes out in order.
REQ-032 's', DataValid with DataByte=0xA5 continuously, echo bytes pending -> TxData alternates echo/0xA5, one DataAck per 0xA5 transfer.
REQ-033 TxValid high in SEND_DATA, send 'S' -> byte still transfers unchanged, no further data grants.
REQ-034 With CMD_SCHED_STATUS_EN, echo on, stream off, '?' -> transmits 63 then 0x31; without macro -> only 63.

Source files
------------

// File: rtl/cmd_tx_scheduler.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// cmd_tx_scheduler
//
// Purpose:
//   Shares one UART transmitter between two sources:
//     - an echo FIFO that holds received command bytes, and
//     - a stream of data bytes from the acquisition datapath.
//   Received bytes also set the mode flags:
//     'e' turns echo off, 'E' turns echo on,
//     's' turns streaming on, 'S' turns streaming off.
//   When both sources are pending, a round-robin arbiter grants them in turn.
//
// Optional feature (macro CMD_SCHED_STATUS_EN):
//   A received '?' also pushes one status byte after its echo:
//     0x30 | {Overflow, StreamEnabled, EchoEnabled}
//   and this clears Overflow.
//   When the macro is undefined, '?' is an ordinary byte.
//
// Handshakes:
//   Tx side:   a byte moves on every rising edge where TxValid && TxReady.
//              Once TxValid is high, TxValid and TxData hold steady until
//              that transfer happens.
//   Data side: DataValid stays high until DataAck pulses for one cycle,
//              in the same cycle as the transfer.
//
// Ports:
//   Clock, Reset            clock; synchronous active-high reset
//   RxData[7:0], RxValid    received byte and its one-cycle strobe
//   DataByte[7:0]           stream byte
//   DataValid, DataAck      stream byte handshake
//   TxData[7:0], TxValid    byte offered to the transmitter
//   TxReady                 transmitter ready
//   EchoEnabled             mode flag
//   StreamEnabled           mode flag
//   Overflow                sticky flag: an echo byte was dropped
//   DbgState[1:0]           scheduler state, for observation only
// -----------------------------------------------------------------------------
module cmd_tx_scheduler #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] RxData,
    input  logic       RxValid,
    input  logic [7:0] DataByte,
    input  logic       DataValid,
    output logic       DataAck,
    output logic [7:0] TxData,
    output logic       TxValid,
    input  logic       TxReady,
    output logic       EchoEnabled,
    output logic       StreamEnabled,
    output logic       Overflow,
    output logic [1:0] DbgState
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND_ECHO = 2'd1,
        ST_SEND_DATA = 2'd2
    } state_t;

    // ------------------------------------------------------------------ state
    state_t          state_q, state_d;
    logic            last_echo_q, last_echo_d;   // 1: echo was granted last
    logic            echo_en_q, echo_en_d;
    logic            stream_en_q, stream_en_d;
    logic            overflow_q, overflow_d;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    logic            pop;
    logic            push_a_req, push_a, drop_a;
    logic            fifo_full;

`ifdef CMD_SCHED_STATUS_EN
    logic            stat_req, push_b, drop_b;
    logic [7:0]      stat_byte;
    logic [AW-1:0]   wr_b_ptr;
`endif

    // ------------------------------------------------------------ mode decode
    always_comb begin
        echo_en_d   = echo_en_q;
        stream_en_d = stream_en_q;
        if (RxValid) begin
            case (RxData)
                8'h65:   echo_en_d   = 1'b0;   // 'e'
                8'h45:   echo_en_d   = 1'b1;   // 'E'
                8'h73:   stream_en_d = 1'b1;   // 's'
                8'h53:   stream_en_d = 1'b0;   // 'S'
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------ echo FIFO
    // Fullness is judged on the count before this cycle's pop. A byte that
    // arrives while the FIFO is full is dropped, even if a pop frees a slot
    // in the same cycle.
    always_comb begin
        fifo_full  = (count_q == DEPTH_C);
        push_a_req = RxValid && echo_en_q;     // pre-update echo flag
        push_a     = push_a_req && !fifo_full;
        drop_a     = push_a_req && fifo_full;
    end

`ifdef CMD_SCHED_STATUS_EN
    // The status byte goes in behind the echoed '?'. It needs a free slot
    // after the echo byte has taken its own.
    always_comb begin
        stat_req  = RxValid && (RxData == 8'h3F);
        push_b    = stat_req && ((count_q + CW'(push_a)) < DEPTH_C);
        drop_b    = stat_req && !push_b;
        stat_byte = 8'h30 | {5'b0, overflow_q, stream_en_q, echo_en_q};
        wr_b_ptr  = wr_ptr_q + AW'(push_a);
    end

    always_comb begin
        overflow_d = overflow_q;
        if (drop_a || drop_b) overflow_d = 1'b1;
        else if (stat_req)    overflow_d = 1'b0;
        count_d  = count_q + CW'(push_a) + CW'(push_b) - CW'(pop);
        wr_ptr_d = wr_ptr_q + AW'(push_a) + AW'(push_b);
        rd_ptr_d = rd_ptr_q + AW'(pop);
    end
`else
    always_comb begin
        overflow_d = overflow_q | drop_a;
        count_d    = count_q + CW'(push_a) - CW'(pop);
        wr_ptr_d   = wr_ptr_q + AW'(push_a);
        rd_ptr_d   = rd_ptr_q + AW'(pop);
    end
`endif

    // FIFO storage is not reset; only the pointers and the count need it.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            if (push_a) mem_q[wr_ptr_q] <= RxData;
`ifdef CMD_SCHED_STATUS_EN
            if (push_b) mem_q[wr_b_ptr] <= stat_byte;
`endif
        end
    end

    // ------------------------------------------------------------ scheduler
    // In IDLE, TxValid and TxData are held at zero. Each transfer therefore
    // returns through IDLE for one cycle, so transfers are at least two
    // cycles apart.
    always_comb begin
        state_d     = state_q;
        last_echo_d = last_echo_q;
        TxValid     = 1'b0;
        TxData      = 8'h00;
        DataAck     = 1'b0;
        pop         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if ((count_q != '0) && DataValid && stream_en_q)
                    state_d = last_echo_q ? ST_SEND_DATA : ST_SEND_ECHO;
                else if (count_q != '0)
                    state_d = ST_SEND_ECHO;
                else if (DataValid && stream_en_q)
                    state_d = ST_SEND_DATA;
            end
            ST_SEND_ECHO: begin
                // The head stays fixed until popped; pushes land in other slots.
                TxValid = 1'b1;
                TxData  = mem_q[rd_ptr_q];
                if (TxReady) begin
                    pop         = 1'b1;
                    last_echo_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            ST_SEND_DATA: begin
                // StreamEnabled is not checked here: a byte on offer is never
                // withdrawn.
                TxValid = 1'b1;
                TxData  = DataByte;
                if (TxReady) begin
                    DataAck     = 1'b1;
                    last_echo_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------ registers
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            last_echo_q <= 1'b0;
            echo_en_q   <= 1'b1;
            stream_en_q <= 1'b0;
            overflow_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            last_echo_q <= last_echo_d;
            echo_en_q   <= echo_en_d;
            stream_en_q <= stream_en_d;
            overflow_q  <= overflow_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    assign EchoEnabled   = echo_en_q;
    assign StreamEnabled = stream_en_q;
    assign Overflow      = overflow_q;
    assign DbgState      = state_q;

endmodule

// File: tb/tb_cmd_tx_scheduler.sv
`timescale 1ns/1ps
// Testbench for cmd_tx_scheduler with directed vectors.
// Inputs are driven 1 ns after each rising edge. Transfers and DataAck
// pulses are logged on the falling edge.
module tb_cmd_tx_scheduler;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] RxData = 8'h00;
  logic       RxValid = 1'b0;
  logic [7:0] DataByte = 8'h00;
  logic       DataValid = 1'b0;
  logic       DataAck;
  logic [7:0] TxData;
  logic       TxValid;
  logic       TxReady = 1'b1;
  logic       EchoEnabled, StreamEnabled, Overflow;
  logic [1:0] DbgState;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] got_q[$];
  int ack_cnt = 0;

  cmd_tx_scheduler #(.FIFO_DEPTH(4)) dut (
    .Clock(Clock), .Reset(Reset),
    .RxData(RxData), .RxValid(RxValid),
    .DataByte(DataByte), .DataValid(DataValid), .DataAck(DataAck),
    .TxData(TxData), .TxValid(TxValid), .TxReady(TxReady),
    .EchoEnabled(EchoEnabled), .StreamEnabled(StreamEnabled),
    .Overflow(Overflow), .DbgState(DbgState)
  );

  // ---------------------------------------------------------- clock / reset
  always #5 Clock = ~Clock;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Transfer log: inputs and state are stable at the falling edge, so these
  // values are the ones the next rising edge will act on.
  always @(negedge Clock) begin
    if (!Reset) begin
      if (TxValid && TxReady) got_q.push_back(TxData);
      if (DataAck) ack_cnt++;
    end
  end

  // ---------------------------------------------------------- driver tasks
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic drain(input int n);
    repeat (n) tick();
  endtask

  task automatic send_rx(input logic [7:0] b);
    RxData  = b;
    RxValid = 1'b1;
    tick();
    RxValid = 1'b0;
  endtask

  task automatic do_reset();
    Reset     = 1'b1;
    RxValid   = 1'b0;
    DataValid = 1'b0;
    TxReady   = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
    got_q.delete();
    ack_cnt = 0;
  endtask

  // ---------------------------------------------------------- tests
  task automatic test_reset();
    // Reset wins over an RxValid arriving in the same cycle.
    Reset = 1'b1; RxValid = 1'b1; RxData = 8'h41;
    tick();
    tick();
    RxValid = 1'b0; Reset = 1'b0;
    n_vec++; if (TxValid !== 1'b0) begin n_err++; $display("FAIL reset_txvalid: got %b expected 0", TxValid); end
    n_vec++; if (TxData !== 8'h00) begin n_err++; $display("FAIL reset_txdata: got %h expected 00", TxData); end
    n_vec++; if (DataAck !== 1'b0) begin n_err++; $display("FAIL reset_dataack: got %b expected 0", DataAck); end
    n_vec++; if (EchoEnabled !== 1'b1) begin n_err++; $display("FAIL reset_echo: got %b expected 1", EchoEnabled); end
    n_vec++; if (StreamEnabled !== 1'b0) begin n_err++; $display("FAIL reset_stream: got %b expected 0", StreamEnabled); end
    n_vec++; if (Overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b expected 0", Overflow); end
    drain(6);
    n_vec++; if (got_q.size() !== 0) begin n_err++; $display("FAIL reset_no_tx: got %0d transfers expected 0", got_q.size()); end
  endtask

  task automatic test_echo_latency();
    do_reset();
    send_rx(8'h41);
    n_vec++; if (TxValid !== 1'b0) begin n_err++; $display("FAIL lat_n1: got %b expected 0", TxValid); end
    tick();
    n_vec++; if (TxValid !== 1'b1) begin n_err++; $display("FAIL lat_n2_valid: got %b expected 1", TxValid); end
    n_vec++; if (TxData !== 8'h41) begin n_err++; $display("FAIL lat_n2_data: got %h expected 41", TxData); end
    tick();
    n_vec++; if (TxValid !== 1'b0) begin n_err++; $display("FAIL lat_idle_after: got %b expected 0", TxValid); end
    drain(6);
    n_vec++;
    if (got_q.size() !== 1) begin n_err++; $display("FAIL lat_count: got %0d expected 1", got_q.size()); end
    else if (got_q[0] !== 8'h41) begin n_err++; $display("FAIL lat_byte: got %h expected 41", got_q[0]); end
  endtask

  task automatic test_echo_modes();
    do_reset();
    send_rx(8'h65);                         // 'e' is still echoed
    n_vec++; if (EchoEnabled !== 1'b0) begin n_err++; $display("FAIL mode_e: got %b expected 0", EchoEnabled); end
    send_rx(8'h42);                         // 'B' is not echoed
    drain(10);
    send_rx(8'h45);                         // 'E' arrives while echo is off
    n_vec++; if (EchoEnabled !== 1'b1) begin n_err++; $display("FAIL mode_E: got %b expected 1", EchoEnabled); end
    drain(10);
    n_vec++;
    if (got_q.size() !== 1) begin n_err++; $display("FAIL mode_count: got %0d expected 1", got_q.size()); end
    else if (got_q[0] !== 8'h65) begin n_err++; $display("FAIL mode_byte: got %h expected 65", got_q[0]); end
  endtask

  task automatic test_overflow();
    logic [7:0] exp_q[$];
    exp_q = '{8'h10, 8'h11, 8'h12, 8'h13};
    do_reset();
    TxReady = 1'b0;
    for (int i = 0; i < 6; i++) send_rx(8'h10 + 8'(i));
    tick();
    n_vec++; if (Overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b expected 1", Overflow); end
    n_vec++; if (TxValid !== 1'b1) begin n_err++; $display("FAIL ovf_held_valid: got %b expected 1", TxValid); end
    n_vec++; if (TxData !== 8'h10) begin n_err++; $display("FAIL ovf_held_data: got %h expected 10", TxData); end
    TxReady = 1'b1;
    drain(20);
    n_vec++;
    if (got_q.size() !== exp_q.size()) begin
      n_err++; $display("FAIL ovf_count: got %0d expected %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_vec++;
        if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL ovf_order[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
      end
    end
    n_vec++; if (Overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b expected 1", Overflow); end
  endtask

  task automatic test_back_to_back();
    // Six bytes on consecutive cycles: the FIFO is pushed and popped in the
    // same cycle, and the pointers wrap past depth 4.
    logic [7:0] exp_q[$];
    exp_q = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26};
    do_reset();
    for (int i = 0; i < 6; i++) send_rx(8'h21 + 8'(i));
    drain(16);
    n_vec++;
    if (got_q.size() !== exp_q.size()) begin
      n_err++; $display("FAIL b2b_count: got %0d expected %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_vec++;
        if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL b2b_order[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
      end
    end
    n_vec++; if (Overflow !== 1'b0) begin n_err++; $display("FAIL b2b_no_overflow: got %b expected 0", Overflow); end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_q[$];
    bit done;
    exp_q = '{8'h73, 8'hA5, 8'h31, 8'hA5, 8'h32, 8'hA5, 8'hA5};
    do_reset();
    TxReady = 1'b0;
    send_rx(8'h73);
    send_rx(8'h31);
    send_rx(8'h32);
    DataByte = 8'hA5; DataValid = 1'b1;
    drain(2);
    n_vec++; if (TxData !== 8'h73) begin n_err++; $display("FAIL rr_first_offer: got %h expected 73", TxData); end
    TxReady = 1'b1;
    done = 1'b0;
    for (int k = 0; k < 60 && !done; k++) begin
      tick();
      if (ack_cnt == 4) begin
        DataValid = 1'b0;
        done = 1'b1;
      end
    end
    n_vec++; if (!done) begin n_err++; $display("FAIL rr_timeout: got %0d acks expected 4", ack_cnt); end
    drain(6);
    n_vec++;
    if (got_q.size() !== exp_q.size()) begin
      n_err++; $display("FAIL rr_count: got %0d expected %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_vec++;
        if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rr_order[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
      end
    end
    n_vec++; if (ack_cnt !== 4) begin n_err++; $display("FAIL rr_acks: got %0d expected 4", ack_cnt); end
  endtask

  task automatic test_stream_withdraw();
    logic [7:0] exp_q[$];
    exp_q = '{8'h5A, 8'h53};
    do_reset();
    send_rx(8'h73);
    drain(6);
    got_q.delete();
    ack_cnt = 0;
    TxReady = 1'b0;
    DataByte = 8'h5A; DataValid = 1'b1;
    drain(3);
    n_vec++; if (TxValid !== 1'b1) begin n_err++; $display("FAIL sw_offer_valid: got %b expected 1", TxValid); end
    send_rx(8'h53);                         // 'S' while a data byte is on offer
    tick();
    n_vec++; if (StreamEnabled !== 1'b0) begin n_err++; $display("FAIL sw_stream_off: got %b expected 0", StreamEnabled); end
    n_vec++; if (TxValid !== 1'b1) begin n_err++; $display("FAIL sw_still_valid: got %b expected 1", TxValid); end
    n_vec++; if (TxData !== 8'h5A) begin n_err++; $display("FAIL sw_still_data: got %h expected 5a", TxData); end
    TxReady = 1'b1;
    drain(12);
    n_vec++;
    if (got_q.size() !== exp_q.size()) begin
      n_err++; $display("FAIL sw_count: got %0d expected %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_vec++;
        if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL sw_order[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
      end
    end
    n_vec++; if (ack_cnt !== 1) begin n_err++; $display("FAIL sw_acks: got %0d expected 1", ack_cnt); end
    DataValid = 1'b0;
  endtask

  task automatic test_reset_mid_transfer();
    do_reset();
    TxReady = 1'b0;
    send_rx(8'h5A);
    tick();
    n_vec++; if (TxValid !== 1'b1) begin n_err++; $display("FAIL rm_offer: got %b expected 1", TxValid); end
    Reset = 1'b1; RxValid = 1'b1; RxData = 8'h51;
    tick();
    Reset = 1'b0; RxValid = 1'b0; TxReady = 1'b1;
    n_vec++; if (TxValid !== 1'b0) begin n_err++; $display("FAIL rm_dropped: got %b expected 0", TxValid); end
    drain(8);
    n_vec++; if (got_q.size() !== 0) begin n_err++; $display("FAIL rm_no_tx: got %0d transfers expected 0", got_q.size()); end
  endtask

  task automatic test_status();
    logic [7:0] exp_q[$];
`ifdef CMD_SCHED_STATUS_EN
    exp_q = '{8'h3F, 8'h31};
`else
    exp_q = '{8'h3F};
`endif
    do_reset();
    send_rx(8'h3F);
    drain(12);
    n_vec++;
    if (got_q.size() !== exp_q.size()) begin
      n_err++; $display("FAIL status_count: got %0d expected %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_vec++;
        if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL status_byte[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
      end
    end
  endtask

  // ---------------------------------------------------------- sequence + report
  initial begin
    test_reset();
    test_echo_latency();
    test_echo_modes();
    test_overflow();
    test_back_to_back();
    test_round_robin();
    test_stream_withdraw();
    test_reset_mid_transfer();
    test_status();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
